truth_table_checker: RTL and testbench



---
 rtl/truth_table_checker.sv | 105 ++++++++++
 tb/tb_truth_table_checker.sv | 130 +++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// Response-side checker for truth-table streams: compares each accepted (row, out)
// pair against the EXPECTED table and reports pass/fail, error count and first bad row.
module truth_table_checker #(
  parameter int                        N_IN     = 2,
  parameter int                        N_OUT    = 1,
  parameter int                        ROWS     = 2**N_IN,
  parameter logic [ROWS*N_OUT-1:0]     EXPECTED = 4'b0110,
  parameter int                        CW       = $clog2(ROWS+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_row,
  input  logic [N_OUT-1:0]  in_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CW-1:0]     err_count,
  output logic              first_err_valid,
  output logic [N_IN-1:0]   first_err_row
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [N_IN:0]     row_idx_q, row_idx_d;
  logic [CW-1:0]     err_count_q, err_count_d;
  logic              first_err_valid_q, first_err_valid_d;
  logic [N_IN-1:0]   first_err_row_q, first_err_row_d;

  // Unpack the flat parameter into one entry per row for a clean indexed lookup.
  logic [N_OUT-1:0]  exp_row [ROWS];
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_exp
    assign exp_row[gi] = EXPECTED[gi*N_OUT +: N_OUT];
  end

  logic              accept;
  logic              mismatch;
  logic              last_row;

  assign accept   = in_valid && (state_q == RUN);
  assign mismatch = (in_row != row_idx_q[N_IN-1:0]) ||
                    (in_out != exp_row[row_idx_q[N_IN-1:0]]);
  assign last_row = (row_idx_q == (N_IN+1)'(ROWS-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      row_idx_q         <= '0;
      err_count_q       <= '0;
      first_err_valid_q <= 1'b0;
      first_err_row_q   <= '0;
    end else begin
      state_q           <= state_d;
      row_idx_q         <= row_idx_d;
      err_count_q       <= err_count_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_row_q   <= first_err_row_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    row_idx_d         = row_idx_q;
    err_count_d       = err_count_q;
    first_err_valid_d = first_err_valid_q;
    first_err_row_d   = first_err_row_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d           = RUN;
          row_idx_d         = '0;
          err_count_d       = '0;
          first_err_valid_d = 1'b0;
          first_err_row_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          row_idx_d = row_idx_q + (N_IN+1)'(1);
          if (mismatch) begin
            err_count_d = err_count_q + CW'(1);
            if (!first_err_valid_q) begin
              first_err_valid_d = 1'b1;
              first_err_row_d   = row_idx_q[N_IN-1:0];
            end
          end
          if (last_row) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready        = (state_q == RUN);
  assign busy            = (state_q == RUN);
  assign done            = (state_q == DONE);
  assign pass            = (state_q == DONE) && (err_count_q == '0);
  assign err_count       = err_count_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_row   = first_err_row_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker (2-input Xor defaults): directed scenarios followed by
// random traffic, all checked against a row-counting reference model.
module tb_truth_table_checker;

  logic       clk = 1'b0;
  logic       reset, start, in_valid;
  logic       in_ready, busy, done, pass;
  logic [1:0] in_row;
  logic [0:0] in_out;
  logic [2:0] err_count;
  logic       first_err_valid;
  logic [1:0] first_err_row;

  int checks = 0;
  int errors = 0;

  // Reference model: whether a pass is open/finished, rows taken, errors seen.
  bit m_run = 0, m_done = 0, m_fv = 0;
  int m_acc = 0, m_errs = 0, m_fr = 0;

  always #5 clk = ~clk;

  truth_table_checker dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .in_out(in_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_valid(first_err_valid), .first_err_row(first_err_row)
  );

  function automatic int xor_of(input int r);
    return (r & 1) ^ ((r >> 1) & 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, advance model on the edge, compare after the edge.
  task automatic step(input bit rst, input bit st, input bit v, input int row, input int out);
    bit mism;
    bit took;
    reset = rst; start = st; in_valid = v; in_row = 2'(row); in_out = 1'(out);
    @(posedge clk);
    took = 0;
    if (rst) begin
      m_run = 0; m_done = 0; m_acc = 0; m_errs = 0; m_fv = 0; m_fr = 0;
    end else if (m_run) begin
      if (v) begin
        took = 1;
        mism = (row != m_acc) || (out != xor_of(m_acc));
        if (mism) begin
          m_errs++;
          if (!m_fv) begin m_fv = 1; m_fr = m_acc; end
        end
        m_acc++;
        if (m_acc == 4) begin m_run = 0; m_done = 1; end
      end
    end else if (st) begin
      m_run = 1; m_done = 0; m_acc = 0; m_errs = 0; m_fv = 0; m_fr = 0;
    end
    #1;
    if (took)
      $display("row accepted: in_row=%0d in_out=%0d -> err_count=%0d first_err=%0b/%0d done=%0b",
               row, out, err_count, first_err_valid, first_err_row, done);
    check("in_ready", 32'(in_ready), 32'(m_run));
    check("busy", 32'(busy), 32'(m_run));
    check("done", 32'(done), 32'(m_done));
    check("pass", 32'(pass), 32'(m_done && m_errs == 0));
    check("err_count", 32'(err_count), 32'(m_errs));
    check("first_err_valid", 32'(first_err_valid), 32'(m_fv));
    check("first_err_row", 32'(first_err_row), 32'(m_fr));
  endtask

  task automatic good_row(input int r);
    step(0, 0, 1, r, xor_of(r));
  endtask

  initial begin
    int rr, oo;
    // Reset state
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);             // in_valid in IDLE ignored
    // All rows correct
    step(0, 1, 0, 0, 0);
    for (int r = 0; r < 4; r++) good_row(r);
    step(0, 0, 1, 3, 0);             // in_valid in DONE ignored
    check("directed pass", 32'(pass), 32'd1);
    // Single bad output on row 2
    step(0, 1, 0, 0, 0);
    good_row(0); good_row(1); step(0, 0, 1, 2, 0); good_row(3);
    check("directed bad row", 32'(first_err_row), 32'd2);
    // Order violation 0,2,1,3 then an extra row in DONE
    step(0, 1, 0, 0, 0);
    good_row(0); good_row(2); good_row(1); good_row(3);
    step(0, 0, 1, 3, 1);
    check("directed order errs", 32'(err_count), 32'd2);
    // Gapped in_valid with start held mid-RUN
    step(0, 1, 0, 0, 0);
    for (int r = 0; r < 4; r++) begin
      good_row(r);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
    end
    // Reset after two accepts, one erroneous
    step(0, 1, 0, 0, 0);
    good_row(0); step(0, 0, 1, 1, 0);
    step(1, 1, 1, 2, 1);
    step(0, 1, 0, 0, 0);
    for (int r = 0; r < 4; r++) good_row(r);
    // Restart from a failing DONE
    step(0, 1, 0, 0, 0);
    good_row(0); good_row(1); good_row(2); step(0, 0, 1, 3, 1);
    step(0, 1, 0, 0, 0);
    for (int r = 0; r < 4; r++) good_row(r);
    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rr = ($urandom_range(0, 9) < 8) ? (m_acc % 4) : int'($urandom_range(0, 3));
      oo = ($urandom_range(0, 9) < 8) ? xor_of(rr) : 1 - xor_of(rr);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) != 0, rr, oo);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
